// File: rtl/gen3_scramble_ctrl.sv
// Gen3 128b/130b per-lane scrambler sequencer: tracks block boundaries, classifies
// blocks, owns the 23-bit Galois LFSR and emits word + per-byte key + bypass mask.
// Latency 1 cycle (all outputs registered together); no backpressure, valid_i=0 freezes state.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, block_start_i       word strobe, word-0-of-block marker
//   sync_header_i, data_in       block sync header (word 0 only), four symbols (symbol 0 in [7:0])
//   scramble_enable_i            global scramble enable level
//   valid_o, data_o              registered word strobe and data
//   lfsr_scramble_value_o        per-byte key, byte n keys symbol n
//   training_sequence_o          per-byte bypass (1 = send unscrambled)
//   scramble_enable_o            registered scramble enable
//   hdr_err_o, align_err_o       one-cycle error pulses aligned with valid_o
module gen3_scramble_ctrl #(
  parameter logic [22:0] LANE_SEED = 23'h1DBFBC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        block_start_i,
  input  logic [1:0]  sync_header_i,
  input  logic [31:0] data_in,
  input  logic        scramble_enable_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] lfsr_scramble_value_o,
  output logic [3:0]  training_sequence_o,
  output logic        scramble_enable_o,
  output logic        hdr_err_o,
  output logic        align_err_o
);

  localparam logic [22:0] TAPS = 23'h210125;

  typedef enum logic [2:0] {
    ALIGN, DATA, OS_TS, OS_SKP, OS_EIEOS, OS_OTHER, BAD
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [22:0] lfsr_q, lfsr_d;

  logic        valid_q, se_q, hdr_err_q, align_err_q;
  logic [31:0] data_q, key_q;
  logic [3:0]  ts_q;

  // 32 Galois steps from the current state: key bits LSB first, plus the
  // advanced state. Key is produced even when the block holds the LFSR.
  logic [31:0] key;
  logic [22:0] lfsr_adv;
  always_comb begin
    lfsr_adv = lfsr_q;
    key      = '0;
    for (int k = 0; k < 32; k++) begin
      key[k]   = lfsr_adv[22];
      lfsr_adv = {lfsr_adv[21:0], 1'b0} ^ (lfsr_adv[22] ? TAPS : 23'h0);
    end
  end

  logic       accept, advance, hdr_err, align_err;
  state_t     word_cls;
  logic [1:0] word_idx;
  logic [3:0] mask;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    lfsr_d    = lfsr_q;
    accept    = 1'b0;
    advance   = 1'b0;
    hdr_err   = 1'b0;
    align_err = 1'b0;
    word_cls  = state_q;
    word_idx  = wcnt_q;
    mask      = 4'b0000;

    if (valid_i) begin
      if (block_start_i) begin
        // A new block always restarts at word 0; any block in progress is dropped.
        accept    = 1'b1;
        align_err = (wcnt_q != 2'd0);
        word_idx  = 2'd0;
        case (sync_header_i)
          2'b10: word_cls = DATA;
          2'b01: begin
            case (data_in[7:0])
              8'h1E, 8'h2D: word_cls = OS_TS;
              8'hAA:        word_cls = OS_SKP;
              8'h00:        word_cls = OS_EIEOS;
              default:      word_cls = OS_OTHER;
            endcase
          end
          default: begin
            word_cls = BAD;
            hdr_err  = 1'b1;
          end
        endcase
      end else if (state_q != ALIGN) begin
        accept = 1'b1;
      end
    end

    if (accept) begin
      case (word_cls)
        DATA:     begin mask = 4'b0000; advance = 1'b1; end
        OS_TS:    begin mask = (word_idx == 2'd0) ? 4'b0001 : 4'b0000; advance = 1'b1; end
        OS_SKP:   begin mask = 4'b1111; advance = 1'b0; end
        OS_EIEOS: begin mask = 4'b1111; advance = 1'b1; end
        OS_OTHER: begin mask = 4'b1111; advance = 1'b1; end
        default:  begin mask = 4'b1111; advance = 1'b0; end
      endcase

      lfsr_d = advance ? lfsr_adv : lfsr_q;
      // EIEOS reseeds only when its last word completes normally.
      if (word_cls == OS_EIEOS && word_idx == 2'd3) lfsr_d = LANE_SEED;

      if (word_idx == 2'd3) begin
        wcnt_d  = 2'd0;
        state_d = ALIGN;
      end else begin
        wcnt_d  = word_idx + 2'd1;
        state_d = word_cls;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ALIGN;
      wcnt_q      <= 2'd0;
      lfsr_q      <= LANE_SEED;
      valid_q     <= 1'b0;
      data_q      <= '0;
      key_q       <= '0;
      ts_q        <= 4'b0000;
      se_q        <= 1'b0;
      hdr_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      lfsr_q      <= lfsr_d;
      valid_q     <= accept;
      hdr_err_q   <= accept & hdr_err;
      align_err_q <= accept & align_err;
      // Payload outputs hold their last value on idle or dropped cycles.
      if (accept) begin
        data_q <= data_in;
        key_q  <= key;
        ts_q   <= mask;
        se_q   <= scramble_enable_i;
      end
    end
  end

  assign valid_o               = valid_q;
  assign data_o                = data_q;
  assign lfsr_scramble_value_o = key_q;
  assign training_sequence_o   = ts_q;
  assign scramble_enable_o     = se_q;
  assign hdr_err_o             = hdr_err_q;
  assign align_err_o           = align_err_q;

endmodule

// File: tb/tb_gen3_scramble_ctrl.sv
// Directed bench for gen3_scramble_ctrl with a reference model feeding a scoreboard queue.
// Expected words are pushed when driven and popped when valid_o is observed one cycle later.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_gen3_scramble_ctrl;

  localparam logic [22:0] SEED = 23'h1DBFBC;
  localparam logic [22:0] POLY = 23'h210125;

  localparam int C_DATA = 0, C_TS = 1, C_SKP = 2, C_EIE = 3, C_OTH = 4, C_BAD = 5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        block_start_i;
  logic [1:0]  sync_header_i;
  logic [31:0] data_in;
  logic        scramble_enable_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic [31:0] lfsr_scramble_value_o;
  logic [3:0]  training_sequence_o;
  logic        scramble_enable_o;
  logic        hdr_err_o;
  logic        align_err_o;

  gen3_scramble_ctrl #(.LANE_SEED(SEED)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .valid_i               (valid_i),
    .block_start_i         (block_start_i),
    .sync_header_i         (sync_header_i),
    .data_in               (data_in),
    .scramble_enable_i     (scramble_enable_i),
    .valid_o               (valid_o),
    .data_o                (data_o),
    .lfsr_scramble_value_o (lfsr_scramble_value_o),
    .training_sequence_o   (training_sequence_o),
    .scramble_enable_o     (scramble_enable_o),
    .hdr_err_o             (hdr_err_o),
    .align_err_o           (align_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] key;
    logic [3:0]  mask;
    logic        se;
    logic        hdr;
    logic        align;
  } exp_t;

  exp_t sb[$];
  exp_t last_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [22:0] m_lfsr;
  int          m_cls;
  int          m_pos;
  logic        m_in_blk;

  function automatic logic [22:0] step1(input logic [22:0] s);
    if (s[22]) return {s[21:0], 1'b0} ^ POLY;
    return {s[21:0], 1'b0};
  endfunction

  function automatic logic [31:0] key_of(input logic [22:0] s);
    logic [22:0] t;
    logic [31:0] k;
    t = s;
    k = '0;
    for (int i = 0; i < 32; i++) begin
      k[i] = t[22];
      t = step1(t);
    end
    return k;
  endfunction

  function automatic logic [22:0] adv32(input logic [22:0] s);
    logic [22:0] t;
    t = s;
    for (int i = 0; i < 32; i++) t = step1(t);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    valid_i = 1'b0;
    block_start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_key", lfsr_scramble_value_o, 32'd0);
    chk("rst_mask", {28'd0, training_sequence_o}, 32'd0);
    chk("rst_se", {31'd0, scramble_enable_o}, 32'd0);
    chk("rst_hdr", {31'd0, hdr_err_o}, 32'd0);
    chk("rst_align", {31'd0, align_err_o}, 32'd0);
    rst_i = 1'b0;
    m_lfsr = SEED;
    m_cls = C_DATA;
    m_pos = 0;
    m_in_blk = 1'b0;
    last_out = '0;
    sb.delete();
  endtask

  task automatic send_word(input logic vld, input logic bs, input logic [1:0] hdr,
                           input logic [31:0] dat, input logic se);
    exp_t e;
    exp_t got;
    logic acc;
    int   idx;
    int   cls;
    valid_i = vld;
    block_start_i = bs;
    sync_header_i = hdr;
    data_in = dat;
    scramble_enable_i = se;
    acc = 1'b0;
    idx = 0;
    cls = m_cls;
    e = '0;
    if (vld) begin
      if (bs) begin
        acc = 1'b1;
        e.align = (m_pos != 0);
        if (hdr == 2'b10) cls = C_DATA;
        else if (hdr == 2'b01) begin
          if (dat[7:0] == 8'h1E || dat[7:0] == 8'h2D) cls = C_TS;
          else if (dat[7:0] == 8'hAA) cls = C_SKP;
          else if (dat[7:0] == 8'h00) cls = C_EIE;
          else cls = C_OTH;
        end else cls = C_BAD;
        e.hdr = (cls == C_BAD);
        m_cls = cls;
      end else if (m_in_blk) begin
        acc = 1'b1;
        idx = m_pos;
      end
    end
    if (acc) begin
      e.data = dat;
      e.se = se;
      e.key = key_of(m_lfsr);
      if (cls == C_DATA) e.mask = 4'b0000;
      else if (cls == C_TS) e.mask = (idx == 0) ? 4'b0001 : 4'b0000;
      else e.mask = 4'b1111;
      if (cls != C_SKP && cls != C_BAD) m_lfsr = adv32(m_lfsr);
      if (cls == C_EIE && idx == 3) m_lfsr = SEED;
      if (idx == 3) begin
        m_in_blk = 1'b0;
        m_pos = 0;
      end else begin
        m_in_blk = 1'b1;
        m_pos = idx + 1;
      end
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    chk("valid_o", {31'd0, valid_o}, {31'd0, acc});
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("data_o", data_o, got.data);
        chk("key", lfsr_scramble_value_o, got.key);
        chk("mask", {28'd0, training_sequence_o}, {28'd0, got.mask});
        chk("se_o", {31'd0, scramble_enable_o}, {31'd0, got.se});
        chk("hdr_err", {31'd0, hdr_err_o}, {31'd0, got.hdr});
        chk("align_err", {31'd0, align_err_o}, {31'd0, got.align});
        last_out = got;
      end
    end else begin
      chk("hold_data", data_o, last_out.data);
      chk("hold_key", lfsr_scramble_value_o, last_out.key);
      chk("idle_hdr", {31'd0, hdr_err_o}, 32'd0);
      chk("idle_align", {31'd0, align_err_o}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_word(1'b0, 1'b0, 2'b00, $urandom, 1'b1);
  endtask

  task automatic send_block(input logic [1:0] hdr, input logic [7:0] b0, input logic se);
    logic [31:0] w;
    w = $urandom;
    w[7:0] = b0;
    send_word(1'b1, 1'b1, hdr, w, se);
    for (int i = 1; i < 4; i++) send_word(1'b1, 1'b0, 2'b00, $urandom, se);
  endtask

  initial begin
    valid_i = 1'b0;
    block_start_i = 1'b0;
    sync_header_i = 2'b00;
    data_in = '0;
    scramble_enable_i = 1'b0;
    rst_i = 1'b1;
    do_reset();

    // Words without block_start in ALIGN are dropped
    send_word(1'b1, 1'b0, 2'b10, 32'hDEADBEEF, 1'b1);

    // First DATA block keys from the seed
    send_word(1'b1, 1'b1, 2'b10, 32'h12345678, 1'b1);
    chk("seed_key0", {24'd0, lfsr_scramble_value_o[7:0]}, 32'h6C);
    chk("seed_mask0", {28'd0, training_sequence_o}, 32'h0);
    for (int i = 1; i < 4; i++) send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);

    // TS1 and TS2 ordered sets
    send_block(2'b01, 8'h1E, 1'b1);
    send_block(2'b01, 8'h2D, 1'b1);

    // DATA, SKP, DATA
    send_block(2'b10, 8'h55, 1'b1);
    send_block(2'b01, 8'hAA, 1'b1);
    send_block(2'b10, 8'h66, 1'b1);

    // Other ordered set, then EIEOS reload, then DATA from the seed again
    send_block(2'b01, 8'h55, 1'b1);
    send_block(2'b01, 8'h00, 1'b1);
    send_word(1'b1, 1'b1, 2'b10, 32'h0BADF00D, 1'b1);
    chk("eieos_key0", {24'd0, lfsr_scramble_value_o[7:0]}, 32'h6C);
    for (int i = 1; i < 4; i++) send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);

    // block_start at wcnt=2: align error, new block restarts at word 0
    send_word(1'b1, 1'b1, 2'b10, $urandom, 1'b1);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);
    send_block(2'b10, 8'h11, 1'b1);

    // Abandoned EIEOS must not reload the LFSR
    send_word(1'b1, 1'b1, 2'b01, 32'h0, 1'b1);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);
    send_block(2'b10, 8'h22, 1'b1);

    // Invalid headers: hdr error, all bypassed, LFSR held
    send_block(2'b11, 8'h10, 1'b1);
    send_block(2'b00, 8'h20, 1'b1);
    send_block(2'b10, 8'h33, 1'b1);

    // Gaps mid-block with scramble enable toggling
    send_word(1'b1, 1'b1, 2'b10, $urandom, 1'b1);
    idle(2);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b0);
    idle(1);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);
    idle(3);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b0);
    send_block(2'b01, 8'h1E, 1'b0);

    // Reset mid-block; next block restarts from the seed
    send_word(1'b1, 1'b1, 2'b10, $urandom, 1'b1);
    send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);
    do_reset();
    send_word(1'b1, 1'b1, 2'b10, 32'hCAFEF00D, 1'b1);
    chk("post_rst_key0", {24'd0, lfsr_scramble_value_o[7:0]}, 32'h6C);
    for (int i = 1; i < 4; i++) send_word(1'b1, 1'b0, 2'b00, $urandom, 1'b1);

    // Mixed traffic
    for (int b = 0; b < 12; b++) begin
      case ($urandom_range(0, 5))
        0: send_block(2'b10, 8'h44, $urandom_range(0, 1) == 1);
        1: send_block(2'b01, 8'h1E, 1'b1);
        2: send_block(2'b01, 8'hAA, 1'b1);
        3: send_block(2'b01, 8'h00, 1'b0);
        4: send_block(2'b01, 8'h77, 1'b1);
        default: send_block(2'b11, 8'h00, 1'b1);
      endcase
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen3_scramble_ctrl.md
# gen3_scramble_ctrl

Per-lane sequencer for the Gen3 (128b/130b) byte scrambler datapath on a 32-bit, 4-symbol-per-cycle lane interface. It tracks 128-bit block boundaries, classifies each block from its sync header and first symbol, and owns the 23-bit LFSR (seed, advance, hold, reload). Each cycle it presents a registered word plus the matching per-byte scramble key and bypass mask to the downstream combinational scrambler.

## Interface
Parameters:
- LANE_SEED, 23'h1DBFBC, LFSR value loaded on reset and on EIEOS reload.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  data_in carries a 32-bit word this cycle.
- block_start_i  in  1  this word is word 0 of a 128-bit block; qualified by valid_i.
- sync_header_i  in  2  block sync header; sampled only with block_start_i.
- data_in  in  32  four symbols; symbol n in bits [8n+7:8n], symbol 0 first on the wire.
- scramble_enable_i  in  1  global scrambling enable (level).
- valid_o  out  1  outputs below carry a word.
- data_o  out  32  registered copy of data_in.
- lfsr_scramble_value_o  out  32  per-byte key; byte n = key for symbol n.
- training_sequence_o  out  4  per-byte bypass; 1 = byte sent unscrambled.
- scramble_enable_o  out  1  registered scramble_enable_i.
- hdr_err_o  out  1  one-cycle pulse: invalid sync header (2'b00/2'b11).
- align_err_o  out  1  one-cycle pulse: block_start_i received while word counter != 0.

## Operation
- States: ALIGN (reset state, no block in progress), DATA, OS_TS, OS_SKP, OS_EIEOS, OS_OTHER, BAD. Word counter wcnt 0..3.
- ALIGN: valid words without block_start_i are dropped (valid_o stays 0, LFSR held).
- On valid_i & block_start_i: classify from sync_header_i and data_in[7:0]:
  - 2'b10 -> DATA: all 16 bytes scrambled, LFSR advances.
  - 2'b01 and byte 0x1E or 0x2D -> OS_TS: symbol 0 bypassed, symbols 1..15 scrambled, LFSR advances.
  - 2'b01 and 0xAA -> OS_SKP: all bypassed, LFSR held for whole block.
  - 2'b01 and 0x00 -> OS_EIEOS: all bypassed, LFSR advances; after word 3, LFSR := LANE_SEED.
  - 2'b01, any other byte -> OS_OTHER: all bypassed, LFSR advances.
  - 2'b00/2'b11 -> BAD: hdr_err_o pulse, all bypassed, LFSR held.
- Each accepted word increments wcnt; after wcnt==3, wcnt wraps to 0 and state returns to ALIGN; the next word must carry block_start_i.
- block_start_i with wcnt != 0: align_err_o pulse; current block abandoned (no EIEOS reload); word classified as a new block word 0.
- LFSR: Galois, x^23+x^21+x^16+x^8+x^5+x^2+1, taps mask 23'h210125. One step: out = L[22]; L := {L[21:0],1'b0} ^ (L[22] ? 23'h210125 : 0). Each byte consumes 8 steps; out of step k is key bit k (LSB first). A word advances 32 steps, byte 0 first.
- Key bytes are output even for bypassed bytes; bypass is only via training_sequence_o. Unused key for held LFSR = key the held state would produce.
- scramble_enable_i=0: scramble_enable_o=0; LFSR still advances/holds/reloads per block rules.
- valid_i=0: no state, counter or LFSR change; valid_o=0, other outputs hold.

## Timing
- Latency 1 cycle: all outputs registered together from the accepted word.
- Reset values: valid_o=0, data_o=0, lfsr_scramble_value_o=0, training_sequence_o=4'b0000, scramble_enable_o=0, hdr_err_o=0, align_err_o=0; LFSR=LANE_SEED, state ALIGN, wcnt=0.
- Reset mid-block: block discarded; first post-reset block keys start from LANE_SEED.
- EIEOS reload takes effect for the very next accepted word.
- Error pulses coincide with valid_o of the offending word.

## Test plan
- Reset, DATA block word 0 -> valid_o one cycle later, lfsr_scramble_value_o[7:0]=8'h6C, training_sequence_o=4'b0000; LFSR state after byte 0 = 23'h498C2E.
- TS1 block (hdr 2'b01, byte0 0x1E) -> word 0 training_sequence_o=4'b0001, words 1..3 4'b0000; keys continue LFSR sequence.
- DATA, SKP, DATA -> second DATA block keys identical to DATA, DATA with no SKP; SKP words have training_sequence_o=4'b1111.
- Any blocks, then EIEOS, then DATA -> DATA word 0 key byte 0 = 8'h6C.
- block_start_i at wcnt=2 -> align_err_o=1 with that word; hdr 2'b11 -> hdr_err_o=1, mask 4'b1111, LFSR unchanged.
- valid_i gaps mid-block and scramble_enable_i toggle -> key sequence unchanged vs gap-free run; scramble_enable_o follows input with 1-cycle lag.
